// File: rtl/delay_scale_estimator.sv
// delay_scale_estimator: recovers the (delay, scale) pair that makes delay_and_scale map a
// reference stream onto an observed stream, via an exhaustive correlation lag search and a bit-serial divide.
module delay_scale_estimator #(
    parameter int WINDOW_LOG2 = 6
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               start_in,
    input  logic               ready_in,
    input  logic signed [15:0] ref_in,
    input  logic signed [15:0] obs_in,
    output logic               busy_out,
    output logic               done_out,
    output logic [7:0]         delay_out,
    output logic [4:0]         scale_out,
    output logic               no_match_out
);
    localparam int W  = 1 << WINDOW_LOG2;
    localparam int AW = 32 + WINDOW_LOG2;
    localparam int PW = AW + 5;
    localparam logic [9:0] CAP_LAST = 10'(256 + W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SEARCH,
        S_ENERGY,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [15:0]       r_refMem [512];
    logic signed [15:0]       r_obsMem [W];
    logic [8:0]               r_wrPtr;
    logic [8:0]               r_winBase;
    logic [9:0]               r_count;
    logic [WINDOW_LOG2-1:0]   r_k;
    logic [7:0]               r_d;
    logic [7:0]               r_bestD;
    logic signed [AW-1:0]     r_acc;
    logic signed [AW-1:0]     r_bestCorr;
    logic [AW-1:0]            r_energy;
    logic [4:0]               r_q;
    logic [2:0]               r_bit;

    logic                     w_lastK;
    logic [7:0]               w_lagSel;
    logic [8:0]               w_refAddr;
    logic signed [15:0]       w_refSample;
    logic signed [15:0]       w_obsSample;
    logic signed [31:0]       w_mulA;
    logic signed [31:0]       w_mulB;
    logic signed [31:0]       w_prod;
    logic signed [AW-1:0]     w_prodExt;
    logic signed [AW-1:0]     w_sum;
    logic [4:0]               w_trial;
    logic [PW-1:0]            w_trialProd;
    logic [PW-1:0]            w_corrScaled;
    logic                     w_noMatch;

    // obs[k] is sample n = 256+k; r_winBase holds the history slot of that first window sample,
    // so lag d reads slot r_winBase + k - d - 1 (wrapping mod 512).
    assign w_lastK     = &r_k;
    assign w_lagSel    = (r_state == S_SEARCH) ? r_d : r_bestD;
    assign w_refAddr   = r_winBase + 9'(r_k) - 9'(w_lagSel) - 9'd1;
    assign w_refSample = r_refMem[w_refAddr];
    assign w_obsSample = r_obsMem[r_k];

    assign w_mulA      = (r_state == S_SEARCH) ? 32'(w_obsSample) : 32'(w_refSample);
    assign w_mulB      = 32'(w_refSample);
    assign w_prod      = w_mulA * w_mulB;
    assign w_prodExt   = AW'(w_prod);
    assign w_sum       = r_acc + w_prodExt;

    assign w_trial      = r_q | (5'd1 << r_bit);
    assign w_trialProd  = PW'(w_trial) * PW'(r_energy);
    assign w_corrScaled = {$unsigned(r_bestCorr), 5'd0};
    assign w_noMatch    = r_bestCorr[AW-1] || (r_bestCorr == '0) || (r_energy == '0);

    // Sample storage has no reset; contents only matter after a complete capture.
    always_ff @(posedge clk_in) begin
        if (r_state == S_CAPTURE && ready_in) begin
            r_refMem[r_wrPtr] <= ref_in;
            if (r_count >= 10'd256) begin
                r_obsMem[r_count[WINDOW_LOG2-1:0]] <= obs_in;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start_in) w_next = S_CAPTURE;
            S_CAPTURE: if (ready_in && r_count == CAP_LAST) w_next = S_SEARCH;
            S_SEARCH:  if (w_lastK && r_d == 8'd255) w_next = S_ENERGY;
            S_ENERGY:  if (w_lastK) w_next = S_DIVIDE;
            S_DIVIDE:  if (r_bit == 3'd0) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath: one MAC per cycle in SEARCH/ENERGY, one quotient bit per cycle in DIVIDE.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
            delay_out    <= '0;
            scale_out    <= '0;
            no_match_out <= 1'b0;
            r_wrPtr      <= '0;
            r_winBase    <= '0;
            r_count      <= '0;
            r_k          <= '0;
            r_d          <= '0;
            r_bestD      <= '0;
            r_acc        <= '0;
            r_bestCorr   <= '0;
            r_energy     <= '0;
            r_q          <= '0;
            r_bit        <= '0;
        end else begin
            done_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        busy_out <= 1'b1;
                        r_count  <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (ready_in) begin
                        r_wrPtr <= r_wrPtr + 9'd1;
                        r_count <= r_count + 10'd1;
                        if (r_count == 10'd256) begin
                            r_winBase <= r_wrPtr;
                        end
                        if (r_count == CAP_LAST) begin
                            r_k        <= '0;
                            r_d        <= '0;
                            r_acc      <= '0;
                            r_bestCorr <= '0;
                            r_bestD    <= '0;
                            r_energy   <= '0;
                        end
                    end
                end
                S_SEARCH: begin
                    r_k <= r_k + WINDOW_LOG2'(1);
                    if (w_lastK) begin
                        r_acc <= '0;
                        if (w_sum > r_bestCorr) begin
                            r_bestCorr <= w_sum;
                            r_bestD    <= r_d;
                        end
                        r_d <= r_d + 8'd1;
                    end else begin
                        r_acc <= w_sum;
                    end
                end
                S_ENERGY: begin
                    r_k      <= r_k + WINDOW_LOG2'(1);
                    r_energy <= r_energy + AW'($unsigned(w_prod));
                    if (w_lastK) begin
                        r_q   <= '0;
                        r_bit <= 3'd4;
                    end
                end
                S_DIVIDE: begin
                    if (w_trialProd <= w_corrScaled) begin
                        r_q <= w_trial;
                    end
                    r_bit <= r_bit - 3'd1;
                end
                S_DONE: begin
                    busy_out     <= 1'b0;
                    done_out     <= 1'b1;
                    no_match_out <= w_noMatch;
                    delay_out    <= w_noMatch ? 8'd0 : r_bestD;
                    scale_out    <= w_noMatch ? 5'd0 : r_q;
                end
                default: ;
            endcase
        end
    end

endmodule
